vram_port_arbiter: RTL and testbench

- Shares the single VRAM access port (R/G/B byte planes, common address bus) between two requesters:
  - the packet-to-pixel write stream from cnv8to24 (addr2vram, data_rgb, wea_r/g/b);
  - a display-side read requester.
- Write stream cannot stall, so writes are buffered in a small FIFO.
- Reads are preferred, except under FIFO watermark pressure or read-burst starvation limits.
- Sits between cnv8to24 and the three VRAM block RAMs in the rx path.

---
 rtl/vram_arb_pkg.sv | 25 ++
 rtl/sync_fifo_fwft.sv | 74 +++++++
 rtl/vram_port_arbiter.sv | 210 +++++++++++++++++++++
 tb/tb_vram_port_arbiter.sv | 351 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vram_arb_pkg.sv
// ---------------------------------------------------------------------------
// vram_arb_pkg
// Shared definitions for the VRAM port arbiter slice.
//   arb_state_t : arbiter FSM encoding (S_RD = read-preferred, S_WR = drain)
//   PLANE_R/G/B : bit positions of the per-plane write enables {r,g,b}
//   entry_w()   : width of one buffered write entry {addr, data, we}
// ---------------------------------------------------------------------------
package vram_arb_pkg;

   typedef enum logic {
      S_RD = 1'b0,
      S_WR = 1'b1
   } arb_state_t;

   localparam int PLANE_R = 2;
   localparam int PLANE_G = 1;
   localparam int PLANE_B = 0;

   // A buffered write carries the full address, one data byte and the
   // three plane enables.
   function automatic int entry_w(input int addr_w);
      return addr_w + 8 + 3;
   endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// ---------------------------------------------------------------------------
// sync_fifo_fwft
// Single-clock first-word-fall-through FIFO with an occupancy count.
// The head entry is visible on dout whenever empty is low; pop consumes it.
// A push while full is accepted only if a pop happens in the same cycle,
// otherwise it is ignored (the caller accounts for the drop).
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   push, din    : write request and entry
//   pop          : consume head entry (only meaningful when not empty)
//   dout         : head entry
//   count        : current occupancy, 0..DEPTH
//   empty, full  : occupancy flags
// ---------------------------------------------------------------------------
module sync_fifo_fwft #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8,
   localparam int AW = $clog2(DEPTH),
   localparam int CW = AW + 1
)(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic [CW-1:0]    count,
   output logic             empty,
   output logic             full
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign empty   = (count == '0);
   assign full    = (count == CW'(DEPTH));
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign dout    = mem[rd_ptr];

   // Storage array has no reset: only slots between rd_ptr and wr_ptr are
   // ever observed, and those are always written before being read.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= din;
      end
   end

   // Pointers wrap naturally because DEPTH is a power of two; the count
   // moves only when exactly one of push/pop takes effect.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/vram_port_arbiter.sv
// ---------------------------------------------------------------------------
// vram_port_arbiter
// Shares the single VRAM port (three byte planes, common address) between
// the non-stallable cnv8to24 write stream and a display read requester.
// Writes are buffered in a FWFT FIFO; reads are preferred unless the FIFO
// crosses its high watermark (drain mode) or reads have starved pending
// writes for MAX_RD_BURST consecutive grants.
// Optional build macro: VRAM_ARB_STATS_EN enables drop_cnt / stall_cnt;
// without it both counters read as zero (fifo_ovf is always present).
// Ports:
//   dclk, rst_n                  : clock, asynchronous active-low reset
//   wr_addr, wr_data, wr_we      : write stream; any wr_we bit = push
//   rd_req, rd_addr              : read request, held until rd_gnt
//   rd_gnt                       : combinational read accept
//   rd_valid, rd_data            : read pixel {r,g,b}, 2 cycles after grant
//   vram_addr, vram_din, vram_we : registered VRAM port
//   vram_dout_r/g/b              : VRAM read data, 1-cycle BRAM latency
//   fifo_ovf                     : sticky dropped-write flag
//   drop_cnt, stall_cnt          : saturating statistics counters
// ---------------------------------------------------------------------------
module vram_port_arbiter
   import vram_arb_pkg::*;
#(
   parameter int ADDR_W       = 24,
   parameter int FIFO_DEPTH   = 8,
   parameter int HI_WM        = 6,
   parameter int LO_WM        = 2,
   parameter int MAX_RD_BURST = 4
)(
   input  logic              dclk,
   input  logic              rst_n,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [7:0]        wr_data,
   input  logic [2:0]        wr_we,
   input  logic              rd_req,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic              rd_gnt,
   output logic              rd_valid,
   output logic [23:0]       rd_data,
   output logic [ADDR_W-1:0] vram_addr,
   output logic [7:0]        vram_din,
   output logic [2:0]        vram_we,
   input  logic [7:0]        vram_dout_r,
   input  logic [7:0]        vram_dout_g,
   input  logic [7:0]        vram_dout_b,
   output logic              fifo_ovf,
   output logic [15:0]       drop_cnt,
   output logic [15:0]       stall_cnt
);

   localparam int EW = entry_w(ADDR_W);
   localparam int CW = $clog2(FIFO_DEPTH) + 1;
   localparam int BW = $clog2(MAX_RD_BURST + 1);
   localparam logic [CW-1:0] HI_C  = CW'(HI_WM);
   localparam logic [CW-1:0] LO_C  = CW'(LO_WM);
   localparam logic [BW-1:0] MAX_B = BW'(MAX_RD_BURST);

   arb_state_t        state;
   logic [BW-1:0]     burst;
   logic [EW-1:0]     fifo_dout;
   logic [CW-1:0]     fifo_count;
   logic [CW-1:0]     next_count;
   logic              fifo_empty;
   logic              fifo_full;
   logic              push_req;
   logic              push_ok;
   logic              drop;
   logic              gnt;
   logic              pop;
   logic              rd_pipe;

   assign push_req = |wr_we;
   assign drop     = push_req && fifo_full && !pop;
   assign push_ok  = push_req && !drop;
   assign rd_gnt   = gnt;

   sync_fifo_fwft #(
      .WIDTH (EW),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (dclk),
      .rst_n (rst_n),
      .push  (push_req),
      .din   ({wr_addr, wr_data, wr_we}),
      .pop   (pop),
      .dout  (fifo_dout),
      .count (fifo_count),
      .empty (fifo_empty),
      .full  (fifo_full)
   );

   // Per-cycle access decision. In S_RD a read wins while the burst budget
   // lasts; once it is spent a pending write goes first, and with nothing
   // pending the read is granted anyway. In S_WR only writes are issued.
   always_comb begin
      gnt = 1'b0;
      pop = 1'b0;
      case (state)
         S_RD: begin
            if (rd_req && (burst < MAX_B)) begin
               gnt = 1'b1;
            end else if (!fifo_empty) begin
               pop = 1'b1;
            end else begin
               gnt = rd_req;
            end
         end
         S_WR: begin
            pop = !fifo_empty;
         end
         default: begin
            gnt = 1'b0;
            pop = 1'b0;
         end
      endcase
   end

   // Occupancy after this cycle's push/pop; watermark decisions use it so
   // the FSM reacts in the same cycle the threshold is crossed.
   always_comb begin
      next_count = fifo_count;
      if (push_ok && !pop) begin
         next_count = fifo_count + CW'(1);
      end else if (pop && !push_ok) begin
         next_count = fifo_count - CW'(1);
      end
   end

   // Arbiter FSM and read-burst counter. The burst counter only tracks
   // starvation, so it restarts whenever a write is served or nothing is
   // waiting.
   always_ff @(posedge dclk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_RD;
         burst <= '0;
      end else begin
         case (state)
            S_RD:    if (next_count >= HI_C) state <= S_WR;
            S_WR:    if (next_count <= LO_C) state <= S_RD;
            default: state <= S_RD;
         endcase
         if (pop || fifo_empty) begin
            burst <= '0;
         end else if (gnt && (burst < MAX_B)) begin
            burst <= burst + BW'(1);
         end
      end
   end

   // VRAM port register stage plus the read-return pipeline. A read leaves
   // vram_din untouched; an idle cycle only deasserts the enables. The
   // two-stage valid pipe lines up with the BRAM output register, and
   // reset empties it so a read in flight never returns.
   always_ff @(posedge dclk or negedge rst_n) begin
      if (!rst_n) begin
         vram_addr <= '0;
         vram_din  <= '0;
         vram_we   <= '0;
         rd_pipe   <= 1'b0;
         rd_valid  <= 1'b0;
      end else begin
         if (gnt) begin
            vram_addr <= rd_addr;
            vram_we   <= '0;
         end else if (pop) begin
            vram_addr <= fifo_dout[EW-1 -: ADDR_W];
            vram_din  <= fifo_dout[10:3];
            vram_we   <= fifo_dout[2:0];
         end else begin
            vram_we   <= '0;
         end
         rd_pipe  <= gnt;
         rd_valid <= rd_pipe;
      end
   end

   // The pixel comes straight from the BRAM output registers; it is forced
   // to zero outside valid cycles so the bus is quiet during and after reset.
   assign rd_data = rd_valid ? {vram_dout_r, vram_dout_g, vram_dout_b} : 24'h0;

   // Sticky overflow flag: set on any dropped push, cleared only by reset.
   always_ff @(posedge dclk or negedge rst_n) begin
      if (!rst_n) begin
         fifo_ovf <= 1'b0;
      end else if (drop) begin
         fifo_ovf <= 1'b1;
      end
   end

`ifdef VRAM_ARB_STATS_EN
   // Saturating statistics: dropped pushes and cycles a pending read waited.
   always_ff @(posedge dclk or negedge rst_n) begin
      if (!rst_n) begin
         drop_cnt  <= '0;
         stall_cnt <= '0;
      end else begin
         if (drop && (drop_cnt != 16'hFFFF)) begin
            drop_cnt <= drop_cnt + 16'd1;
         end
         if (rd_req && !gnt && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
         end
      end
   end
`else
   assign drop_cnt  = 16'h0;
   assign stall_cnt = 16'h0;
`endif

endmodule

// File: tb/tb_vram_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_vram_port_arbiter
// Two arbiter instances share one stimulus stream: u0 uses the default
// parameters, u1 has a large read-burst limit and an unreachable high
// watermark so it can be driven into overflow. Each instance has its own
// synchronous VRAM model and its own queue-based reference model.
// ---------------------------------------------------------------------------
module tb_vram_port_arbiter;

   typedef struct packed {
      logic [23:0] a;
      logic [7:0]  d;
      logic [2:0]  we;
   } ent_t;

   logic        dclk = 1'b0;
   logic        rst_n;
   logic [23:0] wr_addr;
   logic [7:0]  wr_data;
   logic [2:0]  wr_we;
   logic        rd_req;
   logic [23:0] rd_addr;

   logic        gnt_w [2];
   logic        rdv_w [2];
   logic [23:0] rdd_w [2];
   logic [23:0] va_w  [2];
   logic [7:0]  vd_w  [2];
   logic [2:0]  vwe_w [2];
   logic [7:0]  dr_w  [2];
   logic [7:0]  dg_w  [2];
   logic [7:0]  db_w  [2];
   logic        ovf_w [2];
   logic [15:0] dc_w  [2];
   logic [15:0] sc_w  [2];

   // bench VRAM contents (driven by the DUT write port)
   logic [7:0]  vr [2][256];
   logic [7:0]  vg [2][256];
   logic [7:0]  vb [2][256];
   bit          vinit = 0;

   // reference model state
   ent_t        mq [2][$];
   logic [7:0]  mr [2][256];
   logic [7:0]  mg [2][256];
   logic [7:0]  mb [2][256];
   bit          minit = 0;
   bit          drain [2];
   int          burst [2];
   logic [23:0] e_addr [2];
   logic [7:0]  e_din [2];
   logic [2:0]  e_we [2];
   bit          v1 [2];
   bit          v2 [2];
   logic [23:0] d1 [2];
   logic [23:0] d2 [2];
   bit          ovf [2];
   int          drops [2];
   int          stalls [2];
   bit          last_gnt [2];
   int          max_b [2] = '{4, 64};
   int          hi_wm [2] = '{6, 9};
   int          lo_wm [2] = '{2, 2};

   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   int          gnt_cyc0 = -100;
   int          val_cyc0 = -100;
   logic [23:0] val_data0 = '0;
   int          rv_count0 = 0;

   always #5 dclk = ~dclk;

   vram_port_arbiter u0 (
      .dclk(dclk), .rst_n(rst_n),
      .wr_addr(wr_addr), .wr_data(wr_data), .wr_we(wr_we),
      .rd_req(rd_req), .rd_addr(rd_addr),
      .rd_gnt(gnt_w[0]), .rd_valid(rdv_w[0]), .rd_data(rdd_w[0]),
      .vram_addr(va_w[0]), .vram_din(vd_w[0]), .vram_we(vwe_w[0]),
      .vram_dout_r(dr_w[0]), .vram_dout_g(dg_w[0]), .vram_dout_b(db_w[0]),
      .fifo_ovf(ovf_w[0]), .drop_cnt(dc_w[0]), .stall_cnt(sc_w[0])
   );

   vram_port_arbiter #(.MAX_RD_BURST(64), .HI_WM(9)) u1 (
      .dclk(dclk), .rst_n(rst_n),
      .wr_addr(wr_addr), .wr_data(wr_data), .wr_we(wr_we),
      .rd_req(rd_req), .rd_addr(rd_addr),
      .rd_gnt(gnt_w[1]), .rd_valid(rdv_w[1]), .rd_data(rdd_w[1]),
      .vram_addr(va_w[1]), .vram_din(vd_w[1]), .vram_we(vwe_w[1]),
      .vram_dout_r(dr_w[1]), .vram_dout_g(dg_w[1]), .vram_dout_b(db_w[1]),
      .fifo_ovf(ovf_w[1]), .drop_cnt(dc_w[1]), .stall_cnt(sc_w[1])
   );

   function automatic logic [7:0] initPlane(input int p, input int a);
      logic [7:0] v;
      v = 8'(a);
      if (a == 50) return (p == 2) ? 8'hA0 : (p == 1) ? 8'hB0 : 8'hC0;
      return (p == 2) ? (v ^ 8'h5A) : (p == 1) ? (v ^ 8'h3C) : (v ^ 8'hC3);
   endfunction

   // Synchronous BRAM model: read-before-write, one cycle output latency.
   always @(posedge dclk) begin
      if (!vinit) begin
         for (int k = 0; k < 2; k++) begin
            for (int a = 0; a < 256; a++) begin
               vr[k][a] = initPlane(2, a);
               vg[k][a] = initPlane(1, a);
               vb[k][a] = initPlane(0, a);
            end
         end
         vinit = 1;
      end
      for (int k = 0; k < 2; k++) begin
         dr_w[k] <= vr[k][va_w[k][7:0]];
         dg_w[k] <= vg[k][va_w[k][7:0]];
         db_w[k] <= vb[k][va_w[k][7:0]];
         if (vwe_w[k][2]) vr[k][va_w[k][7:0]] <= vd_w[k];
         if (vwe_w[k][1]) vg[k][va_w[k][7:0]] <= vd_w[k];
         if (vwe_w[k][0]) vb[k][va_w[k][7:0]] <= vd_w[k];
      end
   end

   task automatic checkOutput(input string name, input int inst,
                              input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s[u%0d] actual=%0h required=%0h at %0t",
                  name, inst, act, exp, $time);
      end
   endtask

   function automatic int satExp(input int v);
`ifdef VRAM_ARB_STATS_EN
      return (v > 65535) ? 65535 : v;
`else
      return 0 * v;
`endif
   endfunction

   // One model step per instance: compare registered outputs against the
   // expectations from last cycle, decide this cycle's access from the
   // arbitration rules, compare rd_gnt, then advance the model.
   task automatic modelStep(input int i);
      int   n;
      int   m;
      bit   g;
      bit   p;
      ent_t e;
      if (!rst_n) begin
         mq[i].delete();
         drain[i] = 0; burst[i] = 0;
         e_addr[i] = '0; e_din[i] = '0; e_we[i] = '0;
         v1[i] = 0; v2[i] = 0; ovf[i] = 0; drops[i] = 0; stalls[i] = 0;
         last_gnt[i] = 0;
         checkOutput("rst_vram_addr", i, va_w[i], 0);
         checkOutput("rst_vram_din", i, vd_w[i], 0);
         checkOutput("rst_vram_we", i, vwe_w[i], 0);
         checkOutput("rst_rd_valid", i, rdv_w[i], 0);
         checkOutput("rst_rd_data", i, rdd_w[i], 0);
         checkOutput("rst_fifo_ovf", i, ovf_w[i], 0);
         checkOutput("rst_drop_cnt", i, dc_w[i], 0);
         checkOutput("rst_stall_cnt", i, sc_w[i], 0);
         return;
      end
      checkOutput("vram_addr", i, va_w[i], e_addr[i]);
      checkOutput("vram_din", i, vd_w[i], e_din[i]);
      checkOutput("vram_we", i, vwe_w[i], e_we[i]);
      checkOutput("rd_valid", i, rdv_w[i], v2[i]);
      if (v2[i]) checkOutput("rd_data", i, rdd_w[i], d2[i]);
      checkOutput("fifo_ovf", i, ovf_w[i], ovf[i]);
      checkOutput("drop_cnt", i, dc_w[i], satExp(drops[i]));
      checkOutput("stall_cnt", i, sc_w[i], satExp(stalls[i]));

      n = mq[i].size();
      g = 0;
      p = 0;
      if (!drain[i]) begin
         if (rd_req && burst[i] < max_b[i]) g = 1;
         else if (n > 0) p = 1;
         else g = rd_req;
      end else begin
         p = (n > 0);
      end
      checkOutput("rd_gnt", i, gnt_w[i], g);

      v2[i] = v1[i];
      d2[i] = d1[i];
      v1[i] = g;
      if (g) d1[i] = {mr[i][rd_addr[7:0]], mg[i][rd_addr[7:0]], mb[i][rd_addr[7:0]]};
      if (p) begin
         e = mq[i].pop_front();
         e_addr[i] = e.a; e_din[i] = e.d; e_we[i] = e.we;
         if (e.we[2]) mr[i][e.a[7:0]] = e.d;
         if (e.we[1]) mg[i][e.a[7:0]] = e.d;
         if (e.we[0]) mb[i][e.a[7:0]] = e.d;
      end else if (g) begin
         e_addr[i] = rd_addr;
         e_we[i] = '0;
      end else begin
         e_we[i] = '0;
      end
      if (wr_we != 3'b000) begin
         if (n < 8 || p) begin
            e.a = wr_addr; e.d = wr_data; e.we = wr_we;
            mq[i].push_back(e);
         end else begin
            ovf[i] = 1;
            drops[i]++;
         end
      end
      if (rd_req && !g) stalls[i]++;
      if (p || n == 0) burst[i] = 0;
      else if (g && burst[i] < max_b[i]) burst[i]++;
      m = mq[i].size();
      if (!drain[i] && m >= hi_wm[i]) drain[i] = 1;
      else if (drain[i] && m <= lo_wm[i]) drain[i] = 0;
      last_gnt[i] = g;
   endtask

   // Compare process: runs every falling edge, away from the active edge.
   initial begin
      forever begin
         @(negedge dclk);
         if (!minit) begin
            for (int k = 0; k < 2; k++) begin
               for (int a = 0; a < 256; a++) begin
                  mr[k][a] = initPlane(2, a);
                  mg[k][a] = initPlane(1, a);
                  mb[k][a] = initPlane(0, a);
               end
            end
            minit = 1;
         end
         cyc++;
         if (rst_n && gnt_w[0]) gnt_cyc0 = cyc;
         if (rst_n && rdv_w[0]) begin
            val_cyc0 = cyc;
            val_data0 = rdd_w[0];
            rv_count0++;
         end
         for (int k = 0; k < 2; k++) modelStep(k);
      end
   end

   task automatic applyStimulus(input logic [2:0] we, input logic [23:0] wa,
                                input logic [7:0] wd, input logic rq,
                                input logic [23:0] ra);
      @(posedge dclk);
      #1;
      wr_we = we; wr_addr = wa; wr_data = wd; rd_req = rq; rd_addr = ra;
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) applyStimulus(3'b000, 24'h0, 8'h0, 1'b0, 24'h0);
   endtask

   initial begin
      int stall_before;
      int rv_before;
      rst_n = 1'b0;
      wr_we = '0; wr_addr = '0; wr_data = '0; rd_req = 1'b0; rd_addr = '0;
      repeat (3) @(posedge dclk);
      #1 rst_n = 1'b1;
      idle(2);

      $display("[TB] writes only");
      applyStimulus(3'b100, 24'd0, 8'h11, 1'b0, 24'd0);
      applyStimulus(3'b100, 24'd1, 8'h22, 1'b0, 24'd0);
      applyStimulus(3'b100, 24'd2, 8'h33, 1'b0, 24'd0);
      idle(6);
      checkOutput("lit_wr_addr0", 0, vr[0][0], 8'h11);
      checkOutput("lit_wr_addr1", 0, vr[0][1], 8'h22);
      checkOutput("lit_wr_addr2", 0, vr[0][2], 8'h33);
      checkOutput("lit_wr_g_untouched", 0, vg[0][1], 8'h01 ^ 8'h3C);

      $display("[TB] reads only");
      applyStimulus(3'b000, 24'd0, 8'h0, 1'b1, 24'd50);
      idle(4);
      checkOutput("lit_rd_data", 0, val_data0, 24'hA0B0C0);
      checkOutput("lit_rd_latency", 0, val_cyc0 - gnt_cyc0, 2);

      $display("[TB] burst limit");
      stall_before = sc_w[0];
      applyStimulus(3'b010, 24'd200, 8'h77, 1'b0, 24'd0);
      for (int k = 0; k < 7; k++) applyStimulus(3'b000, 24'd0, 8'h0, 1'b1, 24'd60);
      idle(4);
      checkOutput("lit_burst_stall", 0, sc_w[0] - stall_before, satExp(1));
      checkOutput("lit_burst_write", 0, vg[0][200], 8'h77);

      $display("[TB] watermark");
      for (int k = 0; k < 8; k++)
         applyStimulus(3'b001, 24'(120 + k), 8'(8'h90 + k), 1'b1, 24'd70);
      for (int k = 0; k < 10; k++) applyStimulus(3'b000, 24'd0, 8'h0, 1'b1, 24'd70);
      idle(10);

      $display("[TB] overflow");
      for (int k = 0; k < 10; k++)
         applyStimulus(3'b111, 24'(100 + k), 8'(8'h40 + k), 1'b1, 24'd80);
      idle(20);
      checkOutput("lit_ovf_flag", 1, ovf_w[1], 1);
      checkOutput("lit_ovf_drops", 1, dc_w[1], satExp(2));
      checkOutput("lit_ovf_last_kept", 1, vr[1][107], 8'h47);
      checkOutput("lit_ovf_dropped", 1, vr[1][108], 8'h36);
      checkOutput("lit_no_ovf_u0", 0, ovf_w[0], 0);

      $display("[TB] reset mid-read");
      applyStimulus(3'b000, 24'd0, 8'h0, 1'b1, 24'd90);
      @(posedge dclk);
      #1;
      rd_req = 1'b0;
      rst_n = 1'b0;
      rv_before = rv_count0;
      #2;
      checkOutput("lit_rst_vram_addr", 0, va_w[0], 0);
      checkOutput("lit_rst_rd_valid", 0, rdv_w[0], 0);
      repeat (2) @(posedge dclk);
      #1 rst_n = 1'b1;
      idle(5);
      checkOutput("lit_no_valid_after_rst", 0, rv_count0, rv_before);

      $display("[TB] random traffic");
      for (int k = 0; k < 3000; k++) begin
         logic [2:0]  we;
         logic        rq;
         logic [23:0] ra;
         @(posedge dclk);
         #1;
         we = ($urandom_range(0, 9) < 4) ? 3'($urandom_range(1, 7)) : 3'b000;
         if (rd_req && !last_gnt[0]) begin
            rq = 1'b1;
            ra = rd_addr;
         end else begin
            rq = ($urandom_range(0, 2) != 0);
            ra = 24'($urandom_range(0, 255));
         end
         wr_we = we;
         wr_addr = 24'($urandom_range(0, 255));
         wr_data = 8'($urandom);
         rd_req = rq;
         rd_addr = ra;
      end
      idle(20);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
